// File: rtl/ex_addsub_stage.sv
// Two-stage execute slice: ID/EX operand register feeding a ripple add/sub,
// then an output register holding result, ALU flags and branch decision.

module add_sub_64bit (
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        M,
  output logic [63:0] S,
  output logic        Cout
);
  always_comb begin : ripple
    logic [64:0] c;
    logic [63:0] bm;
    bm   = B ^ {64{M}};
    c    = '0;
    c[0] = M;
    S    = '0;
    for (int i = 0; i < 64; i++) begin
      S[i]   = A[i] ^ bm[i] ^ c[i];
      c[i+1] = (A[i] & bm[i]) | (c[i] & (A[i] ^ bm[i]));
    end
    Cout = c[64];
  end
endmodule

module ex_addsub_stage #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            out_taken,
  output logic [3:0]      out_flags,
  output logic            out_illegal
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_BLT  = 4'd6;
  localparam logic [3:0] OP_BGE  = 4'd7;
  localparam logic [3:0] OP_BLTU = 4'd8;
  localparam logic [3:0] OP_BGEU = 4'd9;

  function automatic logic [XLEN-1:0] sel_result(input logic [3:0] op,
                                                  input logic [XLEN-1:0] s,
                                                  input logic lt, input logic ltu);
    case (op)
      OP_ADD, OP_SUB: return s;
      OP_SLT:         return XLEN'(lt);
      OP_SLTU:        return XLEN'(ltu);
      default:        return '0;
    endcase
  endfunction

  function automatic logic sel_taken(input logic [3:0] op, input logic z,
                                     input logic lt, input logic ltu);
    case (op)
      OP_BEQ:  return z;
      OP_BNE:  return !z;
      OP_BLT:  return lt;
      OP_BGE:  return !lt;
      OP_BLTU: return ltu;
      OP_BGEU: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [3:0]      s1_op_q;
  logic [XLEN-1:0] s1_a_q, s1_b_q;
  logic [TAGW-1:0] s1_tag_q;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;
  logic            out_taken_q, out_taken_d;
  logic [3:0]      out_flags_q, out_flags_d;
  logic            out_illegal_q, out_illegal_d;

  logic            s1_load, s2_load;
  logic            sub_m, cout, flag_z, flag_n, flag_v, bm_msb, lt, ltu;
  logic [XLEN-1:0] sum;

  // S1 advancing into S2 frees S1 in the same cycle, so accepts stay bubble-free.
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign s1_load  = in_valid && in_ready && !flush;
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready) && !flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush)        s1_valid_d = 1'b0;
    else if (s1_load) s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid_q <= 1'b0;
    else        s1_valid_q <= s1_valid_d;
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_op_q  <= in_op;
      s1_a_q   <= in_a;
      s1_b_q   <= in_b;
      s1_tag_q <= in_tag;
    end
  end

  // ---- S1 -> S2: add/sub and flag derivation ----
  assign sub_m = (s1_op_q != OP_ADD);

  add_sub_64bit u_addsub (
    .A    (s1_a_q),
    .B    (s1_b_q),
    .M    (sub_m),
    .S    (sum),
    .Cout (cout)
  );

  assign bm_msb = s1_b_q[XLEN-1] ^ sub_m;
  assign flag_z = (sum == '0);
  assign flag_n = sum[XLEN-1];
  assign flag_v = (s1_a_q[XLEN-1] == bm_msb) && (flag_n != s1_a_q[XLEN-1]);
  assign lt     = flag_n ^ flag_v;
  assign ltu    = !cout;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_tag_d     = out_tag_q;
    out_taken_d   = out_taken_q;
    out_flags_d   = out_flags_q;
    out_illegal_d = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (s2_load) begin
      out_valid_d   = 1'b1;
      out_result_d  = sel_result(s1_op_q, sum, lt, ltu);
      out_tag_d     = s1_tag_q;
      out_taken_d   = sel_taken(s1_op_q, flag_z, lt, ltu);
      out_flags_d   = {flag_z, flag_n, cout, flag_v};
      out_illegal_d = (s1_op_q > OP_BGEU);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---- S2: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_taken_q   <= 1'b0;
      out_flags_q   <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= out_tag_d;
      out_taken_q   <= out_taken_d;
      out_flags_q   <= out_flags_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_taken   = out_taken_q;
  assign out_flags   = out_flags_q;
  assign out_illegal = out_illegal_q;
endmodule
